// File: rtl/spike_rate_encoder_if.sv
// Frame/spike bus for spike_rate_encoder.
// master: pixel source and spike consumer; slave: the encoder itself.
interface spike_rate_encoder_if #(
  parameter int INPUTS = 25,
  parameter int PIXW   = 4,
  parameter int TSTEPS = 20
);
  localparam int TW = $clog2(TSTEPS + 1);

  logic [INPUTS*PIXW-1:0] pix_data;
  logic                   pix_valid;
  logic                   pix_ready;
  logic [INPUTS-1:0]      signals;
  logic                   frame_start;
  logic [TW-1:0]          tstep;
  logic                   busy;
  logic                   done;

  modport master (
    output pix_data, pix_valid,
    input  pix_ready, signals, frame_start, tstep, busy, done
  );

  modport slave (
    input  pix_data, pix_valid,
    output pix_ready, signals, frame_start, tstep, busy, done
  );
endinterface

// File: rtl/spike_rate_encoder.sv
// Deterministic rate encoder: latches one frame of pixel intensities and
// emits TSTEPS cycles of spike vectors, each pixel driving an accumulator
// whose carry-out is that pixel's spike for the step.
// Optional build macro SPIKE_RATE_ENCODER_DITHER_EN: accumulators start at
// half scale (rounded, phase-centred spikes) instead of zero (truncating).
module spike_rate_encoder #(
  parameter int INPUTS = 25,
  parameter int PIXW   = 4,
  parameter int TSTEPS = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  spike_rate_encoder_if.slave   bus
);
  localparam int TW = $clog2(TSTEPS + 1);

`ifdef SPIKE_RATE_ENCODER_DITHER_EN
  localparam logic [PIXW-1:0] ACC_INIT = {1'b1, {(PIXW-1){1'b0}}};
`else
  localparam logic [PIXW-1:0] ACC_INIT = '0;
`endif

  typedef enum logic [1:0] {IDLE, INHIB, RUN, DONE} state_t;

  state_t state, state_n;

  logic [INPUTS-1:0][PIXW-1:0] pix_q;
  logic [INPUTS-1:0][PIXW-1:0] acc;
  logic [INPUTS-1:0][PIXW:0]   sum;
  logic [INPUTS-1:0]           carry;
  logic [TW-1:0]               k, k_n;
  logic [INPUTS-1:0]           signals_q;
  logic                        frame_start_q;
  logic                        done_q;
  logic                        ready;
  logic                        accept;

  assign ready  = (state == IDLE) && !rst;
  assign accept = bus.pix_valid && ready;

  // State register; reset wins over any pending transition.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and step-counter logic. k_n is nonzero only when the next
  // state is RUN, so the registered counter doubles as the tstep output.
  always_comb begin
    state_n = state;
    k_n     = '0;
    case (state)
      IDLE:  if (accept) state_n = INHIB;
      INHIB: begin
        state_n = RUN;
        k_n     = TW'(1);
      end
      RUN: begin
        if (k == TW'(TSTEPS)) state_n = DONE;
        else                  k_n     = k + TW'(1);
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Per-pixel accumulate: carry out of the PIXW-bit add is the spike.
  always_comb begin
    sum   = '0;
    carry = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      sum[i]   = {1'b0, acc[i]} + {1'b0, pix_q[i]};
      carry[i] = sum[i][PIXW];
    end
  end

  // Datapath and registered outputs. Outputs are computed from the state
  // being entered so they line up with the cycle that state is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q         <= '0;
      acc           <= '0;
      k             <= '0;
      signals_q     <= '0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      if (accept) begin
        pix_q <= bus.pix_data;
        acc   <= {INPUTS{ACC_INIT}};
      end else if (state_n == RUN) begin
        for (int unsigned i = 0; i < INPUTS; i++) acc[i] <= sum[i][PIXW-1:0];
      end
      k             <= k_n;
      signals_q     <= (state_n == RUN) ? carry : '0;
      frame_start_q <= (state_n == INHIB);
      done_q        <= (state_n == DONE);
    end
  end

  assign bus.pix_ready   = ready;
  assign bus.busy        = !rst && ((state == INHIB) || (state == RUN));
  assign bus.signals     = signals_q;
  assign bus.frame_start = frame_start_q;
  assign bus.done        = done_q;
  assign bus.tstep       = k;
endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder (INPUTS=25, PIXW=4, TSTEPS=20).
module tb_spike_rate_encoder;
  localparam int INPUTS = 25;
  localparam int PIXW   = 4;
  localparam int TSTEPS = 20;
  localparam int TW     = $clog2(TSTEPS + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  spike_rate_encoder_if #(.INPUTS(INPUTS), .PIXW(PIXW), .TSTEPS(TSTEPS)) bus ();

  spike_rate_encoder #(.INPUTS(INPUTS), .PIXW(PIXW), .TSTEPS(TSTEPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [INPUTS*PIXW-1:0] fill(input int v);
    logic [INPUTS*PIXW-1:0] d;
    for (int i = 0; i < INPUTS; i++) d[i*PIXW +: PIXW] = PIXW'(v);
    return d;
  endfunction

  // Accepts a frame from IDLE and records the spike pattern of pixels
  // 0,1,2,24 per step (bit k-1 = step k) plus any spike on other lines.
  task automatic capture(input logic [INPUTS*PIXW-1:0] d,
                         output logic [TSTEPS-1:0] t0, output logic [TSTEPS-1:0] t1,
                         output logic [TSTEPS-1:0] t2, output logic [TSTEPS-1:0] t24,
                         output logic others);
    t0 = '0; t1 = '0; t2 = '0; t24 = '0; others = 1'b0;
    bus.pix_data  = d;
    bus.pix_valid = 1'b1;
    tick();
    bus.pix_valid = 1'b0;
    for (int k = 1; k <= TSTEPS; k++) begin
      tick();
      t0[k-1]  = bus.signals[0];
      t1[k-1]  = bus.signals[1];
      t2[k-1]  = bus.signals[2];
      t24[k-1] = bus.signals[24];
      if (bus.signals[23:3] != '0) others = 1'b1;
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    tick();
    tick();
    checks++;
    if (bus.pix_ready !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_busy: got ready=%b busy=%b expected 0 0", bus.pix_ready, bus.busy);
    end
    checks++;
    if (bus.signals !== '0 || bus.tstep !== '0 || bus.done !== 1'b0 || bus.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got signals=%h tstep=%0d done=%b fs=%b expected 0", bus.signals, bus.tstep, bus.done, bus.frame_start);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.pix_ready !== 1'b1 || bus.busy !== 1'b0 || bus.signals !== '0 || bus.tstep !== '0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got ready=%b busy=%b signals=%h tstep=%0d done=%b expected 1 0 0 0 0",
               bus.pix_ready, bus.busy, bus.signals, bus.tstep, bus.done);
    end
  endtask

  task automatic test_basic_timing();
    logic [INPUTS-1:0] exp_sig;
    bus.pix_data  = fill(8);
    bus.pix_valid = 1'b1;
    tick();
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    checks++;
    if (bus.frame_start !== 1'b1 || bus.signals !== '0 || bus.busy !== 1'b1 || bus.tstep !== '0 || bus.pix_ready !== 1'b0) begin
      failures++;
      $display("FAIL inhib_cycle: got fs=%b signals=%h busy=%b tstep=%0d ready=%b expected 1 0 1 0 0",
               bus.frame_start, bus.signals, bus.busy, bus.tstep, bus.pix_ready);
    end
    for (int k = 1; k <= TSTEPS; k++) begin
      tick();
`ifdef SPIKE_RATE_ENCODER_DITHER_EN
      exp_sig = (k % 2 == 1) ? '1 : '0;
`else
      exp_sig = (k % 2 == 0) ? '1 : '0;
`endif
      checks++;
      if (bus.tstep !== TW'(k) || bus.busy !== 1'b1 || bus.frame_start !== 1'b0 || bus.done !== 1'b0) begin
        failures++;
        $display("FAIL run_step_%0d: got tstep=%0d busy=%b fs=%b done=%b expected %0d 1 0 0", k, bus.tstep, bus.busy, bus.frame_start, bus.done, k);
      end
      checks++;
      if (bus.signals !== exp_sig) begin
        failures++;
        $display("FAIL run_signals_%0d: got %h expected %h", k, bus.signals, exp_sig);
      end
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.pix_ready !== 1'b0 || bus.signals !== '0 || bus.tstep !== '0) begin
      failures++;
      $display("FAIL done_cycle: got done=%b busy=%b ready=%b signals=%h tstep=%0d expected 1 0 0 0 0",
               bus.done, bus.busy, bus.pix_ready, bus.signals, bus.tstep);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.pix_ready !== 1'b1) begin
      failures++;
      $display("FAIL back_to_idle: got done=%b ready=%b expected 0 1", bus.done, bus.pix_ready);
    end
  endtask

  task automatic test_mixed();
    logic [INPUTS*PIXW-1:0] d;
    logic [TSTEPS-1:0] t0, t1, t2, t24;
    logic others;
    d = '0;
    d[1*PIXW +: PIXW]  = 4'd4;
    d[2*PIXW +: PIXW]  = 4'd15;
    d[24*PIXW +: PIXW] = 4'd1;
    capture(d, t0, t1, t2, t24, others);
    checks++;
    if (t0 !== 20'h00000) begin failures++; $display("FAIL mixed_pix0: got %h expected 00000", t0); end
    checks++;
    if (t1 !== 20'h88888) begin failures++; $display("FAIL mixed_pix1: got %h expected 88888", t1); end
    checks++;
    if (t2 !== 20'hEFFFE) begin failures++; $display("FAIL mixed_pix2: got %h expected efffe", t2); end
    checks++;
    if (t24 !== 20'h08000) begin failures++; $display("FAIL mixed_pix24: got %h expected 08000", t24); end
    checks++;
    if (others !== 1'b0) begin failures++; $display("FAIL mixed_zero_lines: got %b expected 0", others); end
  endtask

  task automatic test_dither();
    logic [INPUTS*PIXW-1:0] d;
    logic [TSTEPS-1:0] t0, t1, t2, t24;
    logic others;
    d = '0;
    d[0*PIXW +: PIXW] = 4'd8;
    d[1*PIXW +: PIXW] = 4'd4;
    capture(d, t0, t1, t2, t24, others);
    checks++;
    if (t0 !== 20'h55555) begin failures++; $display("FAIL dither_pix8: got %h expected 55555", t0); end
    checks++;
    if (t1 !== 20'h22222) begin failures++; $display("FAIL dither_pix4: got %h expected 22222", t1); end
    checks++;
    if (t2 !== '0 || t24 !== '0 || others !== 1'b0) begin
      failures++;
      $display("FAIL dither_zero_lines: got %h %h %b expected 0 0 0", t2, t24, others);
    end
  endtask

  task automatic test_back_to_back();
    logic [INPUTS*PIXW-1:0] d;
    logic exp_ready, exp_fs;
    bus.pix_data  = '0;
    bus.pix_valid = 1'b1;
    for (int c = 0; c < 48; c++) begin
      exp_ready = (c % 23 == 0);
      exp_fs    = (c % 23 == 1);
      checks++;
      if (bus.pix_ready !== exp_ready || bus.frame_start !== exp_fs) begin
        failures++;
        $display("FAIL b2b_handshake_c%0d: got ready=%b fs=%b expected %b %b", c, bus.pix_ready, bus.frame_start, exp_ready, exp_fs);
      end
      if (c >= 2 && c < 23) begin
        checks++;
        if (bus.signals !== '0) begin
          failures++;
          $display("FAIL b2b_latched_data_c%0d: got signals=%h expected 0", c, bus.signals);
        end
      end
      if (c >= 1 && c < 22) begin
        for (int i = 0; i < INPUTS; i++) d[i*PIXW +: PIXW] = PIXW'($urandom_range(1, 15));
        bus.pix_data = d;
      end
      tick();
    end
    bus.pix_valid = 1'b0;
    for (int c = 0; c < 40 && !bus.pix_ready; c++) tick();
    checks++;
    if (bus.pix_ready !== 1'b1) begin failures++; $display("FAIL b2b_drain: got ready=%b expected 1", bus.pix_ready); end
  endtask

  task automatic test_midframe_reset();
    int run_cnt;
    int done_at;
    bus.pix_data  = fill(8);
    bus.pix_valid = 1'b1;
    tick();
    bus.pix_valid = 1'b0;
    for (int c = 0; c < 30 && bus.tstep !== TW'(7); c++) tick();
    checks++;
    if (bus.tstep !== TW'(7)) begin failures++; $display("FAIL mr_reach_k7: got tstep=%0d expected 7", bus.tstep); end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.pix_ready !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL mr_during_rst: got ready=%b busy=%b expected 0 0", bus.pix_ready, bus.busy);
    end
    tick();
    checks++;
    if (bus.signals !== '0 || bus.tstep !== '0 || bus.done !== 1'b0 || bus.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL mr_after_edge: got signals=%h tstep=%0d done=%b fs=%b expected 0", bus.signals, bus.tstep, bus.done, bus.frame_start);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.pix_ready !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL mr_idle: got ready=%b busy=%b expected 1 0", bus.pix_ready, bus.busy);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.tstep !== '0) begin
        failures++;
        $display("FAIL mr_no_done_%0d: got done=%b tstep=%0d expected 0 0", c, bus.done, bus.tstep);
      end
    end
    bus.pix_valid = 1'b1;
    tick();
    bus.pix_valid = 1'b0;
    run_cnt = 0;
    done_at = 0;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      if (bus.busy && bus.tstep != '0) run_cnt++;
      if (bus.done) done_at = c;
      if (done_at == 0) tick();
    end
    checks++;
    if (run_cnt != TSTEPS || done_at != 22) begin
      failures++;
      $display("FAIL mr_new_frame: got run_steps=%0d done_cycle=%0d expected 20 22", run_cnt, done_at);
    end
    tick();
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    test_reset();
    test_basic_timing();
`ifdef SPIKE_RATE_ENCODER_DITHER_EN
    test_dither();
`else
    test_mixed();
`endif
    test_back_to_back();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
